// File: rtl/rom_page_loader.sv
// rom_page_loader: maps the ioctl download byte stream onto SDRAM pages through
// a parameter page table, buffers bytes in a small FIFO and writes them to the
// SDRAM port with a request/acknowledge handshake.
//
// Ports:
//   clk_sys, reset              clock, synchronous active-high reset
//   ioctl_download/index/wr/    download port (byte strobe, 25-bit offset,
//   ioctl_addr/dout               8-bit data)
//   mem_we/addr/din, mem_ack    SDRAM write request, held until mem_ack
//   busy                        loader active (OR into system reset)
//   done                        one-cycle pulse when a load fully completes
//   pages_loaded                per-page "has been written" flags
//   overflow                    sticky: a byte was dropped
//   chk_addr, chk_rom           combinational loaded-ROM address classifier
module rom_page_loader #(
  parameter int                 PAGES    = 3,
  parameter logic [PAGES*9-1:0] PAGE_MAP = {9'h107, 9'h100, 9'h000},
  parameter logic [7:0]         INDEX    = 8'd0,
  parameter int                 DEPTH    = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic             mem_we,
  output logic [22:0]      mem_addr,
  output logic [7:0]       mem_din,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done,
  output logic [PAGES-1:0] pages_loaded,
  output logic             overflow,
  input  logic [22:0]      chk_addr,
  output logic             chk_rom
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [10:0]   NPG  = 11'(PAGES);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [22:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t state, state_nxt;
  logic   done_nxt;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;

  logic            active, active_q, active_rise;
  logic [10:0]     pg;
  logic            in_range, strobe, full, push, pop, drop;
  logic [8:0]      map_pg;
  logic [PAGES-1:0] pg_sel, set_bits;

  assign active      = ioctl_download & (ioctl_index == INDEX);
  assign active_rise = active & ~active_q;
  assign pg          = ioctl_addr[24:14];
  assign in_range    = pg < NPG;
  assign strobe      = active & ioctl_wr;
  assign full        = count == FULL;
  // A request is outstanding exactly when the FIFO is non-empty.
  assign pop         = mem_ack & mem_we;
  // Full FIFO still accepts a byte when the head is popped the same cycle.
  assign push        = strobe & in_range & (~full | pop);
  assign drop        = strobe & ~push;
  assign set_bits    = push ? pg_sel : '0;

  always_comb begin
    map_pg = '0;
    pg_sel = '0;
    for (int k = 0; k < PAGES; k++) begin
      if (pg == 11'(k)) begin
        map_pg    = PAGE_MAP[k*9 +: 9];
        pg_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign mem_we   = count != '0;
  assign mem_addr = mem_we ? fifo_q[rd_ptr].addr : '0;
  assign mem_din  = mem_we ? fifo_q[rd_ptr].data : '0;
  assign busy     = state != IDLE;

  // Storage needs no reset: the output mux hides it while empty.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr] <= '{addr: {map_pg, ioctl_addr[13:0]}, data: ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      active_q     <= 1'b0;
      pages_loaded <= '0;
      overflow     <= 1'b0;
      state        <= IDLE;
      done         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      active_q <= active;
      // A new download clears the flags; this cycle's byte still counts.
      if (active_rise) begin
        pages_loaded <= set_bits;
        overflow     <= drop;
      end else begin
        pages_loaded <= pages_loaded | set_bits;
        overflow     <= overflow | drop;
      end
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Completion looks at the next count so that busy drops and done pulses
  // in the cycle right after the last acknowledge.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (active) state_nxt = LOAD;
      LOAD:  if (!active) state_nxt = DRAIN;
      DRAIN: if (count_nxt == '0 && !active_rise) begin
               state_nxt = IDLE;
               done_nxt  = ~active;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    chk_rom = 1'b0;
    for (int k = 0; k < PAGES; k++)
      if (pages_loaded[k] && chk_addr[22:14] == PAGE_MAP[k*9 +: 9]) chk_rom = 1'b1;
  end
endmodule

// File: tb/tb_rom_page_loader.sv
module tb_rom_page_loader;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack = 1'b0;
  logic        busy, done, overflow, chk_rom;
  logic [2:0]  pages_loaded;
  logic [22:0] chk_addr = '0;

  rom_page_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_ack(mem_ack), .busy(busy), .done(done),
    .pages_loaded(pages_loaded), .overflow(overflow), .chk_addr(chk_addr),
    .chk_rom(chk_rom)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [22:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [24:0] ia;
    logic [7:0]  d;
    logic        pushed;
    logic [22:0] ea;
    logic [2:0]  epages;
    logic        eovf;
  } vec_t;
  vec_t tbl[5];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic ack1();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  // Scoreboard: every accepted write is compared with the oldest expectation.
  always @(negedge clk_sys) begin
    if (!reset && mem_we && mem_ack) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected: got write %0h=%0h expected none", mem_addr, mem_din);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_addr", 32'(mem_addr), 32'(e.a));
        chk("sb_data", 32'(mem_din), 32'(e.d));
      end
    end
  end

  initial begin
    bit seen;
    tbl[0] = '{25'h00010,   8'h11, 1'b1, 23'h000010, 3'b011, 1'b0};
    tbl[1] = '{25'h0BFFF,   8'h22, 1'b1, 23'h41FFFF, 3'b111, 1'b0};
    tbl[2] = '{25'h0C000,   8'h33, 1'b0, 23'h000000, 3'b111, 1'b1};
    tbl[3] = '{25'h1FFFFFF, 8'h44, 1'b0, 23'h000000, 3'b111, 1'b1};
    tbl[4] = '{25'h07FFF,   8'h55, 1'b1, 23'h403FFF, 3'b111, 1'b1};

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_din", 32'(mem_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pages", 32'(pages_loaded), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Download 1: single byte into page 1
    ioctl_download = 1'b1;
    tick();
    chk("busy_rise", 32'(busy), 1);
    sb.push_back('{23'h400123, 8'hA5});
    strobe(25'h04123, 8'hA5);
    chk("single_we", 32'(mem_we), 1);
    chk("single_addr", 32'(mem_addr), 32'h400123);
    chk("single_din", 32'(mem_din), 32'hA5);
    ack1();
    chk("single_we_off", 32'(mem_we), 0);
    chk("single_pages", 32'(pages_loaded), 32'h2);

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].pushed) sb.push_back('{tbl[i].ea, tbl[i].d});
      strobe(tbl[i].ia, tbl[i].d);
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].pushed));
      if (tbl[i].pushed) begin
        chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].ea));
        ack1();
      end
      chk($sformatf("v%0d_pages", i), 32'(pages_loaded), 32'(tbl[i].epages));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].eovf));
    end

    // Completion: two queued entries, download dropped, acks after 3 cycles
    sb.push_back('{23'h000100, 8'h71});
    strobe(25'h00100, 8'h71);
    sb.push_back('{23'h000101, 8'h72});
    strobe(25'h00101, 8'h72);
    ioctl_download = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 3; c++) begin
        chk("cmp_busy", 32'(busy), 1);
        chk("cmp_done", 32'(done), 0);
        tick();
      end
      ack1();
    end
    chk("cmp_busy_low", 32'(busy), 0);
    chk("cmp_done_pulse", 32'(done), 1);
    tick();
    chk("cmp_done_once", 32'(done), 0);

    // Download 2: rising edge clears flags, same-cycle byte still counts
    ioctl_download = 1'b1;
    sb.push_back('{23'h000000, 8'h80});
    strobe(25'h00000, 8'h80);
    chk("new_pages", 32'(pages_loaded), 32'h1);
    chk("new_ovf", 32'(overflow), 0);
    ack1();
    sb.push_back('{23'h41C000, 8'h81});
    strobe(25'h08000, 8'h81);
    ack1();
    chk_addr = 23'h41C000; #1;
    chk("lookup_p2", 32'(chk_rom), 1);
    chk_addr = 23'h400000; #1;
    chk("lookup_p1", 32'(chk_rom), 0);
    chk_addr = 23'h003FFF; #1;
    chk("lookup_p0", 32'(chk_rom), 1);

    // Stall and full FIFO: 5 strobes, ack held low
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back('{23'h400000 + 23'(i), 8'(8'h60 + i)});
      strobe(25'h04000 + 25'(i), 8'(8'h60 + i));
      ioctl_wr = 1'b0;
    end
    chk("full_ovf", 32'(overflow), 1);
    chk("full_head", 32'(mem_addr), 32'h400000);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", 32'(mem_we), 1);
      tick();
    end
    mem_ack = 1'b0;
    chk("drain_empty", 32'(mem_we), 0);

    ioctl_download = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("dl2_done", 32'(seen), 1);

    // Wrong index: nothing accepted
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    strobe(25'h00000, 8'h90);
    strobe(25'h04000, 8'h91);
    chk("idx_we", 32'(mem_we), 0);
    chk("idx_busy", 32'(busy), 0);
    chk("idx_pages", 32'(pages_loaded), 32'h7);
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    tick();

    // Reset with 3 queued entries and a coincident ack
    ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{23'h000010 + 23'(i), 8'(8'hB0 + i)});
      strobe(25'h00010 + 25'(i), 8'(8'hB0 + i));
    end
    chk("pre_rst_we", 32'(mem_we), 1);
    reset = 1'b1; mem_ack = 1'b1; ioctl_download = 1'b0;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    sb.delete();
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_din", 32'(mem_din), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_pages", 32'(pages_loaded), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    tick();
    chk("post_rst_we", 32'(mem_we), 0);

    chk("sb_left", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rom_page_loader.md
# rom_page_loader

Parametrised successor to the fixed three-page boot-ROM mapper in the CPC top level. Receives the byte stream from the `mist_io` ioctl download port and maps each 16 KB input page through a parameter page table onto SDRAM page numbers. Buffers bytes in a small FIFO and writes them to the SDRAM port with a request/acknowledge handshake. Holds the system in reset while loading and replaces the hard-coded `rom_mask` with a loaded-page lookup.

## Interface

Parameters:
- `PAGES`, 3: number of mappable 16 KB input pages.
- `PAGE_MAP`, {9'h107, 9'h100, 9'h000}: `PAGES`×9-bit table. Entry k occupies bits [9k+8:9k] and is the SDRAM page (`addr[22:14]`) for input page k.
- `INDEX`, 8'd0: `ioctl_index` value this loader accepts.
- `DEPTH`, 4: FIFO entries (power of two, ≥2).

Ports:
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ioctl_download`  in  1  download active.
- `ioctl_index`  in  8  download target index.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte offset in the download.
- `ioctl_dout`  in  8  byte data.
- `mem_we`  out  1  write request to SDRAM.
- `mem_addr`  out  23  SDRAM byte address.
- `mem_din`  out  8  write data.
- `mem_ack`  in  1  one-cycle pulse: the current request has been accepted.
- `busy`  out  1  loader active; OR this into the system reset.
- `done`  out  1  one-cycle pulse when a load fully completes.
- `pages_loaded`  out  PAGES  bit k set once any byte of page k has been written.
- `overflow`  out  1  sticky: a byte was dropped, either because its page was ≥ `PAGES` or because the FIFO was full.
- `chk_addr`  in  23  address to classify (motherboard `ram_a`).
- `chk_rom`  out  1  combinational: `chk_addr` lies in a loaded mapped page.

## Operation

- `active = ioctl_download & (ioctl_index == INDEX)`.
- Rising edge of `active` clears `pages_loaded` and `overflow`. The write into these flags from the same cycle still applies.
- A byte is pushed when `active & ioctl_wr`, `ioctl_addr[24:14] < PAGES`, and the FIFO is not full.
  - Entry address: `{PAGE_MAP[k], ioctl_addr[13:0]}`, with k = `ioctl_addr[24:14]`.
  - The push sets `pages_loaded[k]`.
- A byte with page ≥ `PAGES`, or one arriving while the FIFO is full, is dropped and sets `overflow`.
- Pushes depend only on `active`, not on the state machine state.
- FSM states:
  - **IDLE**: `busy=0`. Rising `active` → LOAD.
  - **LOAD**: `busy=1`. `active` falls → DRAIN.
  - **DRAIN**: `busy=1`. FIFO empty and no request outstanding → IDLE, pulsing `done` on that transition. If `active` rises again in DRAIN: flags clear, stay in DRAIN, then go IDLE → LOAD on the following cycle.
- Write port:
  - The head entry is presented on `mem_addr`/`mem_din` with `mem_we=1`.
  - Address, data and `mem_we` stay stable until `mem_ack`.
  - On the `mem_ack` cycle the entry is popped.
  - `mem_ack` while `mem_we=0` is ignored.
- `chk_rom = OR over k of (pages_loaded[k] & chk_addr[22:14] == PAGE_MAP[k])`.
  - The top level drives `ram_Din | {8{~chk_rom}}`, so unloaded or unmapped space reads 0xFF.

## Timing

- Reset values:
  - `mem_we=0`, `mem_addr=0`, `mem_din=0`.
  - `busy=0`, `done=0`, `pages_loaded=0`, `overflow=0`.
  - FIFO empty, FSM IDLE.
- Reset mid-load flushes the FIFO and drops any outstanding request, even when `mem_ack` arrives in the same cycle.
- Latency: push in cycle N → `mem_we=1` with that entry from cycle N+1 when the FIFO was empty.
- After `mem_ack` in cycle M:
  - next entry presented in M+1 if the FIFO is non-empty;
  - otherwise `mem_we=0` in M+1.
  - Back-to-back acks therefore give one write per cycle.
- A simultaneous push and pop on a full FIFO is accepted: count stays `DEPTH`, no overflow.
- `busy` rises the cycle after `active` rises.
- `done` fires the cycle after the last `mem_ack` once `active` is low. `busy` is low in that same cycle.
- FIFO pointers wrap modulo `DEPTH`. Count is `clog2(DEPTH)+1` bits.
- `chk_rom` has no register; it reflects `pages_loaded` as updated at the previous edge.

## Test plan

- **Default map, single byte.** Index 0: write 0xA5 at `ioctl_addr` 0x04123.
  - Required: `mem_we` the next cycle, `mem_addr`=0x400123 (page 0x100), `mem_din`=0xA5.
  - Required: after ack, `pages_loaded`=3'b010.
- **Page out of range.** Write at `ioctl_addr` 0x0C000 (page 3).
  - Required: no `mem_we`, `overflow`=1, `pages_loaded` unchanged.
- **Stall and full FIFO.** `DEPTH`=4, `mem_ack` held low, 5 consecutive strobes.
  - Required: 4 entries queued, 5th dropped, `overflow`=1.
  - Required: then acks every cycle → 4 writes in 4 consecutive cycles, in push order.
- **Completion.** Drop `ioctl_download` with 2 entries queued, ack each after 3 cycles.
  - Required: `busy` stays 1 until the cycle after the 2nd ack, then `done` pulses for exactly 1 cycle.
- **Lookup and new download.** After loading pages 0 and 2, `chk_addr`=0x41C000 → `chk_rom`=1 and `chk_addr`=0x400000 → 0.
  - Required: a new download clears `pages_loaded` to 0 and `overflow` to 0 on its rising edge.
- **Wrong index and reset.** `ioctl_index`=1 with strobes → nothing pushed, `busy`=0. Separately, `reset` with 3 entries queued.
  - Required: next cycle `mem_we`=0, FIFO empty, all outputs at reset values.
